// File: rtl/ahb_mem_pkg.sv
// Shared types and helpers for the AHB-Lite memory slave.
package ahb_mem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian byte enables; wide=1 selects a 64-bit bus, else 32-bit.
  // Oversize transfers enable every lane of the bus.
  function automatic logic [7:0] gen_strobe(input logic [2:0] size,
                                            input logic [2:0] addr_lo,
                                            input logic       wide);
    logic [7:0] full;
    logic [7:0] base;
    logic [2:0] offs;
    full = wide ? 8'hFF : 8'h0F;
    offs = wide ? addr_lo : {1'b0, addr_lo[1:0]};
    case (size)
      3'd0:    base = 8'h01 << offs;
      3'd1:    base = 8'h03 << {offs[2:1], 1'b0};
      3'd2:    base = wide ? (8'h0F << {offs[2], 2'b00}) : 8'h0F;
      default: base = 8'hFF;
    endcase
    return base & full;
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Byte-writable RAM with an asynchronous read port; contents are never reset.
module ahb_mem_array
  import ahb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

  // Per-lane write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with programmable wait states and registered responses.
// Define AHB_MEM_ERR_EN to build the two-cycle ERROR response for bad transfers.
module ahb_mem_slave
  import ahb_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic [3:0]            wait_cfg,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int SPAN_W = IDX_W + LANE_W;

  state_e                state_r, nxt_state_s;
  logic [3:0]            cnt_r, nxt_cnt_s;
  logic [IDX_W-1:0]      idx_r, nxt_idx_s, acc_idx_s;
  logic                  write_r, nxt_write_s;
  logic [NBYTES-1:0]     strb_r, nxt_strb_s;
  logic [7:0]            strb8_s;
  logic                  hreadyout_r, nxt_ready_s;
  logic [DATA_WIDTH-1:0] hrdata_r, mem_rdata_s, fwd_s;
  logic                  accept_s, bad_s, busy_s, commit_s, load_s;
  logic                  unused_s;

  assign accept_s = HSEL && HREADY && HTRANS[1];
  assign busy_s   = ((state_r == ST_DATA) && (cnt_r != 4'd0)) || (state_r == ST_ERR1);
  assign commit_s = (state_r == ST_DATA) && (cnt_r == 4'd0) && write_r;
  // BASE_ADDR is aligned to the memory span, so the offset is just the low address bits.
  assign acc_idx_s = HADDR[SPAN_W-1:LANE_W];
  assign strb8_s   = gen_strobe(HSIZE, HADDR[2:0], DATA_WIDTH == 64);
  assign unused_s  = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK, HADDR};

`ifdef AHB_MEM_ERR_EN
  logic in_range_s, oversize_s, unaligned_s;
  assign in_range_s = (HADDR[ADDR_WIDTH-1:SPAN_W] == BASE_ADDR[ADDR_WIDTH-1:SPAN_W]);
  assign oversize_s = (HSIZE > 3'(LANE_W));
  // Alignment check against the transfer size
  always_comb begin
    case (HSIZE)
      3'd0:    unaligned_s = 1'b0;
      3'd1:    unaligned_s = HADDR[0];
      3'd2:    unaligned_s = |HADDR[1:0];
      3'd3:    unaligned_s = |HADDR[2:0];
      default: unaligned_s = 1'b1;
    endcase
  end
  assign bad_s = !in_range_s || oversize_s || unaligned_s;
`else
  assign bad_s = 1'b0;
`endif

  // Next state: stalls take priority, otherwise the cycle is open for a new address phase
  always_comb begin
    nxt_state_s = ST_IDLE;
    nxt_cnt_s   = cnt_r;
    nxt_idx_s   = idx_r;
    nxt_write_s = write_r;
    nxt_strb_s  = strb_r;
    if (busy_s) begin
      if (state_r == ST_DATA) begin
        nxt_state_s = ST_DATA;
        nxt_cnt_s   = cnt_r - 4'd1;
      end else begin
        nxt_state_s = ST_ERR2;
      end
    end else if (accept_s && !bad_s) begin
      nxt_state_s = ST_DATA;
      nxt_cnt_s   = wait_cfg;
      nxt_idx_s   = acc_idx_s;
      nxt_write_s = HWRITE;
      nxt_strb_s  = strb8_s[NBYTES-1:0];
    end else if (accept_s) begin
      nxt_state_s = ST_ERR1;
      nxt_cnt_s   = 4'd0;
    end else begin
      nxt_state_s = ST_IDLE;
      nxt_cnt_s   = 4'd0;
    end
  end

  // Next outputs; a write committing this edge is forwarded into a same-word read
  always_comb begin
    case (nxt_state_s)
      ST_DATA: nxt_ready_s = (nxt_cnt_s == 4'd0);
      ST_ERR1: nxt_ready_s = 1'b0;
      default: nxt_ready_s = 1'b1;
    endcase
    load_s = (nxt_state_s == ST_DATA) && (nxt_cnt_s == 4'd0) && !nxt_write_s;
    fwd_s  = mem_rdata_s;
    for (int b = 0; b < NBYTES; b++) begin
      if (commit_s && strb_r[b] && (idx_r == nxt_idx_s)) begin
        fwd_s[8*b +: 8] = HWDATA[8*b +: 8];
      end else begin
        fwd_s[8*b +: 8] = mem_rdata_s[8*b +: 8];
      end
    end
  end

  // Controller state and registered bus outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      idx_r       <= '0;
      write_r     <= 1'b0;
      strb_r      <= '0;
      hreadyout_r <= 1'b1;
      hrdata_r    <= '0;
    end else begin
      state_r     <= nxt_state_s;
      cnt_r       <= nxt_cnt_s;
      idx_r       <= nxt_idx_s;
      write_r     <= nxt_write_s;
      strb_r      <= nxt_strb_s;
      hreadyout_r <= nxt_ready_s;
      hrdata_r    <= load_s ? fwd_s : hrdata_r;
    end
  end

`ifdef AHB_MEM_ERR_EN
  logic hresp_r;
  // ERROR is driven through both error cycles
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hresp_r <= HRESP_OKAY;
    end else begin
      hresp_r <= ((nxt_state_s == ST_ERR1) || (nxt_state_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end
  end
  assign HRESP = hresp_r;
`else
  assign HRESP = HRESP_OKAY;
`endif

  assign HREADYOUT = hreadyout_r;
  assign HRDATA    = hrdata_r;

  ahb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk   (HCLK),
    .we    (commit_s),
    .waddr (idx_r),
    .wstrb (strb_r),
    .wdata (HWDATA),
    .raddr (nxt_idx_s),
    .rdata (mem_rdata_s)
  );

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Per-cycle vector bench for ahb_mem_slave, plus a hand-written mid-transfer reset sequence.
module tb_ahb_mem_slave;
  import ahb_mem_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  wire         HREADY;
  logic [3:0]  wait_cfg;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  int checks = 0;
  int errors = 0;

  assign HREADY = HREADYOUT;

  ahb_mem_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HREADY(HREADY), .wait_cfg(wait_cfg),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  // One row = inputs driven in a cycle and outputs expected in that same cycle.
  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wcfg;
    logic        rdy;
    logic        resp;
    logic        chk;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] t, input logic w, input logic [2:0] s,
                              input logic [31:0] a, input logic [31:0] d, input logic [3:0] c,
                              input logic r, input logic rs, input logic k, input logic [31:0] e);
    vec_t v;
    v.trans = t; v.wr = w; v.size = s; v.addr = a; v.wdata = d; v.wcfg = c;
    v.rdy = r; v.resp = rs; v.chk = k; v.data = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] c);
    @(posedge HCLK); #1;
    HTRANS = t; HWRITE = w; HSIZE = s; HADDR = a; HWDATA = d; wait_cfg = c;
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b1; HADDR = 32'h0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HSIZE = HSIZE_WORD; HBURST = 3'd1; HPROT = 4'd0; HMASTLOCK = 1'b0; HWDATA = 32'h0;
    wait_cfg = 4'd0;

    // Zero-wait write then back-to-back read of 0x10
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    // Three wait states on a read of 0x20; wait_cfg changes mid-transfer are ignored
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'hCAFEF00D, 4'd0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0,        4'd3, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd9, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D);
    // Byte lanes, then a halfword overwrite of the upper half
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h40, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h41, 32'h00000011, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h42, 32'h00002200, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h43, 32'h00330000, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h44000000, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h42, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'h44332211);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'hBEEF0000, 4'd0, 1'b1, 1'b0, 1'b1, 32'h44332211);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hBEEF2211);
    // INCR burst at 0x80 with a BUSY after beat 2 (its data phase carries junk)
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h80, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h84, 32'hA0000001, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h88, 32'hA0000002, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h88, 32'hFFFFFFFF, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'h8C, 32'hA0000003, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'hA0000004, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h80, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h84, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hA0000001);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h88, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hA0000002);
    add(HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h8C, 32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hA0000003);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0,        4'd0, 1'b1, 1'b0, 1'b1, 32'hA0000004);
    // Seed 0x50 and 0x0
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h50, 32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0,  32'h12345678, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,  32'h0BADF00D, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef AHB_MEM_ERR_EN
    // Out-of-range read: ERR1 then ERR2, with a read of 0x0 accepted during ERR2
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1000, 32'h0,      4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,    32'h0,      4'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0,    32'h0,      4'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,    32'h0,      4'd0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
`else
    // Out-of-range addresses wrap modulo the memory span
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1010, 32'h0,      4'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    add(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1000, 32'h0,      4'd0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    add(HTRANS_IDLE,   1'b0, HSIZE_WORD, 32'h0,    32'h0,      4'd0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
`endif

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    check("reset_hreadyout", 0, {31'd0, HREADYOUT}, 32'd1);
    check("reset_hresp",     0, {31'd0, HRESP},     32'd0);
    check("reset_hrdata",    0, HRDATA,             32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].wcfg);
      @(negedge HCLK);
      check("hreadyout", i, {31'd0, HREADYOUT}, {31'd0, vecs[i].rdy});
      check("hresp",     i, {31'd0, HRESP},     {31'd0, vecs[i].resp});
      if (vecs[i].chk) check("hrdata", i, HRDATA, vecs[i].data);
    end

    // Reset during the wait states of a write to 0x50 must discard it
    drive(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h50, 32'h0, 4'd5);
    drive(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'hBAD0BAD0, 4'd0);
    @(negedge HCLK);
    check("rst_wait_hreadyout", 100, {31'd0, HREADYOUT}, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check("rst_async_hreadyout", 101, {31'd0, HREADYOUT}, 32'd1);
    check("rst_async_hresp",     101, {31'd0, HRESP},     32'd0);
    check("rst_async_hrdata",    101, HRDATA,             32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h50, 32'h0, 4'd0);
    drive(HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 4'd0);
    @(negedge HCLK);
    check("post_rst_hreadyout", 102, {31'd0, HREADYOUT}, 32'd1);
    check("post_rst_hrdata",    102, HRDATA,             32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
